dmem_controller: RTL and testbench

DMEM_CONTROLLER -- requirements
Module: dmem_controller

---
 rtl/core.sv | 35 +++
 rtl/load_align.sv | 17 +
 rtl/dmem_controller.sv | 138 +++++++++++++
 tb/tb_dmem_controller.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/core.sv
// core: shared types and encodings for the data-memory controller.
// Stores carry STORE_PRFX in the top mem_op bit so one bit separates loads from stores.
package core;
    localparam int MEM_OP_BITS = 4;
    localparam logic STORE_PRFX = 1'b1;

    typedef enum logic [MEM_OP_BITS-1:0] {
        MEM_NOP = 4'b0000,
        MEM_LB  = 4'b0001,
        MEM_LH  = 4'b0010,
        MEM_LW  = 4'b0011,
        MEM_LBU = 4'b0100,
        MEM_LHU = 4'b0101,
        MEM_SB  = 4'b1001,
        MEM_SH  = 4'b1010,
        MEM_SW  = 4'b1011
    } mem_op_t;

    typedef struct packed {
        logic [31:0] addr;
        mem_op_t     mem_op;
        logic [31:0] w_data;
        logic [4:0]  mem_rd;
    } mem_cntrl_bus_t;

    typedef enum logic [1:0] {IDLE, REQ, WAIT_R} dmem_state_t;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    function automatic logic is_store(input mem_op_t op);
        return op[MEM_OP_BITS-1] == STORE_PRFX;
    endfunction
endpackage

// File: rtl/load_align.sv
// load_align: shifts a read word down to the accessed lane and sign/zero-extends it.
module load_align
    import core::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  offset_i,
    input  mem_op_t     mem_op_i,
    output logic [31:0] data_o
);
    logic [31:0] lane;

    assign lane   = rdata_i >> {offset_i, 3'b000};
    assign data_o = (mem_op_i == MEM_LB)  ? {{24{lane[7]}}, lane[7:0]}   :
                    (mem_op_i == MEM_LBU) ? {24'b0, lane[7:0]}           :
                    (mem_op_i == MEM_LH)  ? {{16{lane[15]}}, lane[15:0]} :
                    (mem_op_i == MEM_LHU) ? {16'b0, lane[15:0]}          : lane;
endmodule

// File: rtl/dmem_controller.sv
// dmem_controller: single-outstanding data-memory access FSM with lane steering and load extension.
// Define DMEM_TIMEOUT_EN to abort REQ/WAIT_R after TIMEOUT_CYCLES with a bus_err_o pulse.
module dmem_controller
    import core::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  mem_cntrl_bus_t mem_bus_i,
    output logic           stall_o,
    output logic           dmem_req_o,
    output logic           dmem_we_o,
    output logic [31:0]    dmem_addr_o,
    output logic [3:0]     dmem_be_o,
    output logic [31:0]    dmem_wdata_o,
    input  logic           dmem_gnt_i,
    input  logic           dmem_rvalid_i,
    input  logic [31:0]    dmem_rdata_i,
    output logic           wb_valid_o,
    output logic [4:0]     wb_rd_o,
    output logic [31:0]    wb_data_o,
    output logic           misalign_o,
    output logic           bus_err_o
);
    dmem_state_t state_q;
    mem_op_t     op_q;
    logic        done_q, we_q, wb_valid_q, bus_err_q;
    logic [31:0] addr_q, wdata_q, wb_data_q, wdata_d, load_data;
    logic [3:0]  be_q, be_d;
    logic [1:0]  off_q;
    logic [4:0]  rd_q, wb_rd_q;
    logic        mis, idle_ok, accept, timeout;
    mem_op_t     op;

    assign op = mem_bus_i.mem_op;
    assign mis = ((op == MEM_LH || op == MEM_LHU || op == MEM_SH) && mem_bus_i.addr[0]) ||
                 ((op == MEM_LW || op == MEM_SW) && mem_bus_i.addr[1:0] != 2'b00);
    // done_q masks the completed request still held on the bus for one cycle
    assign idle_ok = rst_ni && state_q == IDLE && !done_q;
    assign accept  = idle_ok && op != MEM_NOP && !mis;

    assign misalign_o   = idle_ok && mis;
    assign stall_o      = accept || state_q != IDLE;
    assign dmem_req_o   = state_q == REQ;
    assign dmem_we_o    = dmem_req_o && we_q;
    assign dmem_addr_o  = addr_q;
    assign dmem_be_o    = be_q;
    assign dmem_wdata_o = wdata_q;
    assign wb_valid_o   = wb_valid_q;
    assign wb_rd_o      = wb_rd_q;
    assign wb_data_o    = wb_data_q;
    assign bus_err_o    = bus_err_q;

    assign be_d = (op == MEM_SB) ? BE_BYTE << mem_bus_i.addr[1:0] :
                  (op == MEM_SH) ? BE_HALF << mem_bus_i.addr[1:0] : BE_WORD;
    assign wdata_d = (op == MEM_SB) ? {4{mem_bus_i.w_data[7:0]}}  :
                     (op == MEM_SH) ? {2{mem_bus_i.w_data[15:0]}} : mem_bus_i.w_data;

    load_align u_load_align (
        .rdata_i  (dmem_rdata_i),
        .offset_i (off_q),
        .mem_op_i (op_q),
        .data_o   (load_data)
    );

`ifdef DMEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;

    assign timeout = cnt_q == CW'(TIMEOUT_CYCLES - 1);
    assign cnt_d   = (accept || (state_q == REQ && dmem_gnt_i)) ? '0 :
                     (state_q != IDLE) ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end
`else
    logic unused_timeout_cycles;
    assign timeout = 1'b0;
    assign unused_timeout_cycles = TIMEOUT_CYCLES != 0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            op_q       <= MEM_NOP;
            done_q     <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            off_q      <= '0;
            rd_q       <= '0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            bus_err_q  <= 1'b0;
        end else begin
            wb_valid_q <= 1'b0;
            bus_err_q  <= 1'b0;
            done_q     <= 1'b0;
            case (state_q)
                IDLE: if (accept) begin
                    state_q <= REQ;
                    op_q    <= op;
                    we_q    <= is_store(op);
                    addr_q  <= {mem_bus_i.addr[31:2], 2'b00};
                    off_q   <= mem_bus_i.addr[1:0];
                    be_q    <= be_d;
                    wdata_q <= wdata_d;
                    rd_q    <= mem_bus_i.mem_rd;
                end
                REQ: if (dmem_gnt_i) begin
                    state_q <= we_q ? IDLE : WAIT_R;
                    done_q  <= we_q;
                end else if (timeout) begin
                    state_q   <= IDLE;
                    bus_err_q <= 1'b1;
                    done_q    <= 1'b1;
                end
                WAIT_R: if (dmem_rvalid_i) begin
                    state_q    <= IDLE;
                    wb_valid_q <= 1'b1;
                    wb_rd_q    <= rd_q;
                    wb_data_q  <= load_data;
                    done_q     <= 1'b1;
                end else if (timeout) begin
                    state_q   <= IDLE;
                    bus_err_q <= 1'b1;
                    done_q    <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_controller.sv
// tb_dmem_controller: randomized scoreboard bench for dmem_controller with a reference access model.
module tb_dmem_controller;
    import core::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_cntrl_bus_t bus;
    logic gnt, rvalid;
    logic [31:0] rdata_in;
    logic stall_o, dmem_req_o, dmem_we_o, wb_valid_o, misalign_o, bus_err_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o, wb_data_o;
    logic [3:0] dmem_be_o;
    logic [4:0] wb_rd_o;

    dmem_controller #(.TIMEOUT_CYCLES(16)) dut (
        .clk_i(clk), .rst_ni(rst_n), .mem_bus_i(bus), .stall_o(stall_o),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
        .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o), .dmem_gnt_i(gnt),
        .dmem_rvalid_i(rvalid), .dmem_rdata_i(rdata_in), .wb_valid_o(wb_valid_o),
        .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o), .misalign_o(misalign_o), .bus_err_o(bus_err_o)
    );

    typedef struct {logic [31:0] a; logic [3:0] be; logic [31:0] d; logic we;} req_t;
    typedef struct {logic [4:0] rd; logic [31:0] d;} wb_t;
    req_t req_q[$];
    wb_t  wb_q[$];
    int n_cmp = 0, n_bad = 0;
    int cfg_gd = 0, cfg_rvd = 0, req_age = 0, pend_rv = -1;
    logic [31:0] r_data = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic int op_size(input mem_op_t op);
        case (op)
            MEM_LB, MEM_LBU, MEM_SB: return 1;
            MEM_LH, MEM_LHU, MEM_SH: return 2;
            default: return 4;
        endcase
    endfunction

    function automatic bit op_store(input mem_op_t op);
        return op inside {MEM_SB, MEM_SH, MEM_SW};
    endfunction

    function automatic logic [31:0] ref_load(input mem_op_t op, input logic [1:0] off, input logic [31:0] w);
        logic [31:0] s;
        int v;
        s = w >> (8 * off);
        case (op)
            MEM_LB:  begin v = int'(s & 255); if (v > 127) v -= 256; return 32'(v); end
            MEM_LBU: return s & 255;
            MEM_LH:  begin v = int'(s & 65535); if (v > 32767) v -= 65536; return 32'(v); end
            MEM_LHU: return s & 65535;
            default: return s;
        endcase
    endfunction

    function automatic req_t ref_req(input mem_op_t op, input logic [31:0] a, input logic [31:0] w);
        req_t r;
        r.a = a & ~32'd3;
        r.we = op_store(op);
        r.be = 4'hF;
        r.d = w;
        if (op == MEM_SB) begin r.be = 4'(1 << a[1:0]); r.d = (w & 255) * 32'h01010101; end
        if (op == MEM_SH) begin r.be = 4'(3 << a[1:0]); r.d = (w & 65535) * 32'h00010001; end
        return r;
    endfunction

    // memory responder: grant after cfg_gd REQ cycles, return data cfg_rvd cycles after grant
    initial begin
        gnt = 1'b0; rvalid = 1'b0; rdata_in = '0;
        forever begin
            @(posedge clk); #1;
            gnt = 1'b0; rvalid = 1'b0;
            if (pend_rv >= 0) begin
                if (pend_rv == 0) begin rvalid = 1'b1; rdata_in = r_data; end
                pend_rv--;
            end else if (dmem_req_o) begin
                if (req_age == cfg_gd) begin
                    gnt = 1'b1; req_age = 0;
                    if (!dmem_we_o) pend_rv = cfg_rvd;
                end else begin
                    req_age++;
                    rvalid = 1'($urandom_range(0, 1));
                    rdata_in = $urandom;
                end
            end else req_age = 0;
        end
    end

    always @(negedge clk) if (rst_n) begin
        if (dmem_req_o) begin
            if (req_q.size() == 0) chk("unexp_req", 32'(dmem_req_o), 32'd0);
            else begin
                chk("req_addr", dmem_addr_o, req_q[0].a);
                chk("req_we", 32'(dmem_we_o), 32'(req_q[0].we));
                if (req_q[0].we) begin
                    chk("req_be", 32'(dmem_be_o), 32'(req_q[0].be));
                    chk("req_wdata", dmem_wdata_o, req_q[0].d);
                end
                if (gnt) void'(req_q.pop_front());
            end
        end
        if (wb_valid_o) begin
            if (wb_q.size() == 0) chk("unexp_wb", 32'(wb_valid_o), 32'd0);
            else begin
                chk("wb_data", wb_data_o, wb_q[0].d);
                chk("wb_rd", 32'(wb_rd_o), 32'(wb_q[0].rd));
                void'(wb_q.pop_front());
            end
        end
    end

    task automatic chk_zero(input string nm);
        chk({nm, "_ctl"}, 32'({stall_o, dmem_req_o, dmem_we_o, wb_valid_o, misalign_o, bus_err_o,
                               dmem_be_o, wb_rd_o}), 32'd0);
        chk({nm, "_addr"}, dmem_addr_o, 32'd0);
        chk({nm, "_wdata"}, dmem_wdata_o, 32'd0);
        chk({nm, "_wbdata"}, wb_data_o, 32'd0);
    endtask

    task automatic do_op(input mem_op_t op, input logic [31:0] a, input logic [31:0] w,
                         input logic [4:0] rd, input int gd, input int rvd, input logic [31:0] rdat);
        bit st, mis;
        int stalls;
        st = op_store(op);
        mis = (a % op_size(op)) != 0;
        cfg_gd = gd; cfg_rvd = rvd; r_data = rdat;
        @(posedge clk); #1;
        bus = '{addr: a, mem_op: op, w_data: w, mem_rd: rd};
        if (!mis) begin
            req_q.push_back(ref_req(op, a, w));
            if (!st) wb_q.push_back('{rd: rd, d: ref_load(op, a[1:0], rdat)});
        end
        @(negedge clk);
        chk("misalign", 32'(misalign_o), 32'(mis));
        if (mis) begin
            chk("mis_stall", 32'(stall_o), 32'd0);
            chk("mis_req", 32'(dmem_req_o), 32'd0);
        end else begin
            stalls = 0;
            while (stall_o && stalls < 100) begin stalls++; @(negedge clk); end
            chk("stall_cycles", 32'(stalls), st ? 32'(2 + gd) : 32'(3 + gd + rvd));
            chk("wb_at_fall", 32'(wb_valid_o), 32'(!st));
            chk("bus_err", 32'(bus_err_o), 32'd0);
        end
        @(posedge clk); #1;
        bus.mem_op = MEM_NOP;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        mem_op_t ops[8] = '{MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU, MEM_SB, MEM_SH, MEM_SW};
        bus = '0;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        @(posedge clk); #3 rst_n = 1'b1;

        do_op(MEM_LW, 32'h100, 32'h0, 5'd5, 0, 0, 32'hDEADBEEF);
        do_op(MEM_LB, 32'h103, 32'h0, 5'd9, 0, 0, 32'h80FFFF01);
        do_op(MEM_LBU, 32'h103, 32'h0, 5'd10, 1, 2, 32'h80FFFF01);
        do_op(MEM_SH, 32'h202, 32'h1234ABCD, 5'd0, 3, 0, 32'h0);
        do_op(MEM_SW, 32'h301, 32'h11223344, 5'd0, 0, 0, 32'h0);
        do_op(MEM_LH, 32'h402, 32'h0, 5'd3, 0, 1, 32'h8001_7FFF);

        for (int i = 0; i < 40; i++)
            do_op(ops[$urandom_range(0, 7)], $urandom, $urandom, 5'($urandom),
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom);

        cfg_gd = 0; cfg_rvd = 5; r_data = 32'h55AA55AA;
        @(posedge clk); #1;
        bus = '{addr: 32'h500, mem_op: MEM_LW, w_data: 32'h0, mem_rd: 5'd7};
        req_q.push_back(ref_req(MEM_LW, 32'h500, 32'h0));
        @(posedge clk);
        @(posedge clk); #3;
        rst_n = 1'b0;
        bus.mem_op = MEM_NOP;
        @(negedge clk);
        chk_zero("mid_rst");
        @(posedge clk);
        @(posedge clk); #3 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("rst_wb", 32'(wb_valid_o), 32'd0);
            chk("rst_stall", 32'(stall_o), 32'd0);
        end

`ifdef DMEM_TIMEOUT_EN
        begin
            int stalls;
            cfg_gd = 1000;
            @(posedge clk); #1;
            bus = '{addr: 32'h600, mem_op: MEM_LW, w_data: 32'h0, mem_rd: 5'd4};
            req_q.push_back(ref_req(MEM_LW, 32'h600, 32'h0));
            stalls = 0;
            @(negedge clk);
            while (stall_o && stalls < 100) begin stalls++; @(negedge clk); end
            chk("to_stall", 32'(stalls), 32'd17);
            chk("to_bus_err", 32'(bus_err_o), 32'd1);
            chk("to_wb", 32'(wb_valid_o), 32'd0);
            void'(req_q.pop_front());
            @(posedge clk); #1;
            bus.mem_op = MEM_NOP;
            cfg_gd = 0;
        end
`endif

        repeat (3) @(negedge clk);
        chk("req_q_left", 32'(req_q.size()), 32'd0);
        chk("wb_q_left", 32'(wb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
